// File: rtl/pipe_mux_n.sv
// Pipelined DEPTH-to-1 selector: a level-1 group mux tree and a level-2 group select,
// each followed by a register stage, with elastic valid/ready flow control.
module pipe_mux_n #(
  parameter int unsigned n       = 4,
  parameter int unsigned address = 10,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned s       = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [n-1:0]       data_i [0:DEPTH-1],
  input  logic [address-1:0] sel,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [n-1:0]       data_o,
  output logic               err_o,
  output logic               valid_o,
  input  logic               ready_i
);

  localparam int unsigned SLOTS = 2**address;
  localparam int unsigned GW    = address - s;
  localparam int unsigned GR    = 2**GW;

  logic [n-1:0]  slot_c [0:SLOTS-1];
  logic [n-1:0]  grp_c  [0:GR-1];
  logic [n-1:0]  grp_q  [0:GR-1];
  logic [GW-1:0] hi_q;
  logic          oor_c;
  logic          oor_q;
  logic          v1_q;
  logic          ready2_c;
  logic          accept_c;
  logic          advance_c;
  logic          consume_c;
  logic [n-1:0]  res_c;

  // Pad the tree to a full power of two; unpopulated slots read as zero.
  for (genvar k = 0; k < int'(SLOTS); k++) begin : g_slot
    if (k < int'(DEPTH)) begin : g_pop
      assign slot_c[k] = data_i[k];
    end else begin : g_pad
      assign slot_c[k] = '0;
    end
  end

  // Level 1: one m:1 mux per group, all steered by the low select bits.
  always_comb begin
    for (int g = 0; g < int'(GR); g++) begin
      grp_c[g] = slot_c[{GW'(g), sel[s-1:0]}];
    end
  end

  assign oor_c = (32'(sel) >= DEPTH);

  assign ready2_c  = !valid_o || ready_i;
  assign ready_o   = !v1_q || ready2_c;
  assign accept_c  = valid_i && ready_o;
  assign advance_c = v1_q && ready2_c;
  assign consume_c = valid_o && ready_i;

  // Level 2: pick the registered group; out-of-range requests return zero.
  assign res_c = oor_q ? '0 : grp_q[hi_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      hi_q    <= '0;
      oor_q   <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
      err_o   <= 1'b0;
      for (int g = 0; g < int'(GR); g++) begin
        grp_q[g] <= '0;
      end
    end else begin
      if (accept_c) begin
        hi_q  <= sel[address-1:s];
        oor_q <= oor_c;
        for (int g = 0; g < int'(GR); g++) begin
          grp_q[g] <= grp_c[g];
        end
      end
      v1_q <= accept_c ? 1'b1 : (advance_c ? 1'b0 : v1_q);

      if (advance_c) begin
        data_o <= res_c;
        err_o  <= oor_q;
      end
      valid_o <= advance_c ? 1'b1 : (consume_c ? 1'b0 : valid_o);
    end
  end

endmodule

// File: tb/tb_pipe_mux_n.sv
// Scoreboard bench for pipe_mux_n: a full-depth instance and a DEPTH=1000 instance.
module tb_pipe_mux_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_a, valid_b, ready_i;
  logic [9:0] sel;
  logic [3:0] data_a [0:1023];
  logic [3:0] data_b [0:999];
  logic       ra, ea, va, rb, eb, vb;
  logic [3:0] da, db;
  logic [4:0] q_a [$];
  logic [4:0] q_b [$];
  logic [4:0] e_a, e_b;
  int         checks = 0;
  int         passes = 0;
  int         stall_cnt = 0;

  always #5 clk = ~clk;

  pipe_mux_n #(.n(4), .address(10), .DEPTH(1024), .s(5)) dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(data_a), .sel(sel), .valid_i(valid_a),
    .ready_o(ra), .data_o(da), .err_o(ea), .valid_o(va), .ready_i(ready_i));

  pipe_mux_n #(.n(4), .address(10), .DEPTH(1000), .s(5)) dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(data_b), .sel(sel), .valid_i(valid_b),
    .ready_o(rb), .data_o(db), .err_o(eb), .valid_o(vb), .ready_i(ready_i));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitors: pop one expectation per completed output handshake.
  always @(negedge clk) begin
    if (!rst && va && ready_i) begin
      if (q_a.size() == 0) begin
        checks++;
        $display("FAIL mon_a_unexpected: got result 0x%0h expected none", da);
      end else begin
        e_a = q_a.pop_front();
        check("mon_a_data", 32'(da), 32'(e_a[3:0]));
        check("mon_a_err", 32'(ea), 32'(e_a[4]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vb && ready_i) begin
      if (q_b.size() == 0) begin
        checks++;
        $display("FAIL mon_b_unexpected: got result 0x%0h expected none", db);
      end else begin
        e_b = q_b.pop_front();
        check("mon_b_data", 32'(db), 32'(e_b[3:0]));
        check("mon_b_err", 32'(eb), 32'(e_b[4]));
      end
    end
  end

  // Present one request and hold it until accepted; optionally queue its expected result.
  task automatic issue(input bit to_b, input logic [9:0] s_v, input logic [3:0] ed,
                       input bit ee, input bit track);
    bit done = 1'b0;
    sel = s_v;
    if (to_b) valid_b = 1'b1;
    else valid_a = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (to_b ? rb : ra) begin
        if (track) begin
          if (to_b) q_b.push_back({ee, ed});
          else q_a.push_back({ee, ed});
        end
        done = 1'b1;
      end else begin
        stall_cnt++;
      end
      @(posedge clk); #1;
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL issue_timeout: got no acceptance for sel 0x%0h expected acceptance", s_v);
    end
  endtask

  task automatic drain();
    int c = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && c < 3000) begin
      @(posedge clk);
      c++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q_a.size() + q_b.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 1024; k++) data_a[k] = 4'(k);
    for (int k = 0; k < 1000; k++) data_b[k] = 4'hF;
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; ready_i = 1'b1; sel = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", 32'(va), 32'd0);
    check("rst_data", 32'(da), 32'd0);
    check("rst_err", 32'(ea), 32'd0);
    check("rst_ready", 32'(ra), 32'd1);
    @(posedge clk); #1;

    // Single request, two-cycle latency
    issue(1'b0, 10'h2A7, 4'h7, 1'b0, 1'b1);
    @(negedge clk); check("lat_c1_valid", 32'(va), 32'd0);
    @(negedge clk); check("lat_c2_valid", 32'(va), 32'd1);
    @(negedge clk); check("lat_c3_valid", 32'(va), 32'd0);
    drain();

    // Back-to-back sweep of every slot
    stall_cnt = 0;
    for (int k = 0; k < 1024; k++) issue(1'b0, 10'(k), 4'(k), 1'b0, 1'b1);
    check("sweep_no_stall", 32'(stall_cnt), 32'd0);
    drain();

    // Backpressure: two fill the pipe, third waits until ready_i rises
    ready_i = 1'b0;
    issue(1'b0, 10'd5, 4'd5, 1'b0, 1'b1);
    issue(1'b0, 10'd6, 4'd6, 1'b0, 1'b1);
    fork
      issue(1'b0, 10'd7, 4'd7, 1'b0, 1'b1);
      begin
        @(negedge clk);
        check("stall_ready", 32'(ra), 32'd0);
        check("stall_valid", 32'(va), 32'd1);
        check("stall_data", 32'(da), 32'd5);
        @(negedge clk);
        check("stall_hold", 32'(da), 32'd5);
        @(posedge clk); #1 ready_i = 1'b1;
      end
    join
    drain();

    // Input changes after acceptance do not reach the result
    issue(1'b0, 10'd3, 4'h3, 1'b0, 1'b1);
    data_a[3] = 4'hC;
    drain();
    data_a[3] = 4'h3;

    // Partial depth: last populated slot, then first out-of-range slot
    issue(1'b1, 10'd999, 4'hF, 1'b0, 1'b1);
    issue(1'b1, 10'd1000, 4'h0, 1'b1, 1'b1);
    drain();

    // Reset with two requests in flight drops both
    ready_i = 1'b0;
    issue(1'b0, 10'd10, 4'hA, 1'b0, 1'b0);
    issue(1'b0, 10'd11, 4'hB, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(va), 32'd0);
    check("mid_rst_data", 32'(da), 32'd0);
    check("mid_rst_ready", 32'(ra), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("mid_rst_no_stale", 32'(va), 32'd0);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
- Pipelined, parametrised N-bit wide, DEPTH-to-1 selector built as a two-level tree with a register after each level.
- Supersedes the purely combinational wide mux in the library. Adds a clock, valid/ready flow control, non-power-of-two depth and an out-of-range select flag.
- Sits in the datapath wherever a register-file or table read mux is too wide to close timing in one cycle.

Parameters:
- n, 4, data width in bits.
- address, 10, select width; the tree spans 2**address slots.
- DEPTH, 1024, number of populated inputs; must satisfy 2 ≤ DEPTH ≤ 2**address.
- s, 5, select bits resolved in level 1. Each level-1 group has m = 2**s inputs. There are gr = 2**(address-s) groups. Constraint: 1 ≤ s < address.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  synchronous active-high reset.
- data_i  input  n x DEPTH  unpacked array data_i[0:DEPTH-1] of candidate words.
- sel  input  address  index of the word to forward.
- valid_i  input  1  request valid; data_i and sel are meaningful.
- ready_o  output  1  block can accept a request this cycle.
- data_o  output  n  selected word.
- err_o  output  1  the request's sel was ≥ DEPTH; qualified by valid_o.
- valid_o  output  1  data_o and err_o hold a result.
- ready_i  input  1  downstream accepts the result this cycle.

Behaviour:
- Interface: one clock (clk_i), synchronous active-high reset (rst_i). Reset is sampled only on the rising edge of clk_i.
- Reset values:
  - valid_o = 0, data_o = 0, err_o = 0.
  - Level-1 valid (v1) = 0; level-1 data and upper-select registers = 0.
  - ready_o = 1 in the first cycle after reset is released.
- Level 1:
  - For each group g in [0, gr-1], compute a combinational m:1 mux over slots g*m .. g*m+m-1, indexed by sel[s-1:0].
  - Slots ≥ DEPTH read as 0.
  - On acceptance, register all gr group results, sel[address-1:s], the flag oor = (sel ≥ DEPTH), and set v1 = 1.
- Level 2:
  - gr:1 mux over the registered group results, indexed by the registered upper select.
  - On advance, register the result to data_o, oor to err_o, and set valid_o = 1.
  - If oor is set, data_o is forced to 0.
- Handshake (full-throughput elastic pipeline):
  - ready2 = !valid_o || ready_i.
  - ready_o = !v1 || ready2 (combinational).
  - Request accepted when valid_i && ready_o. Level 1 advances into level 2 when v1 && ready2.
  - Result consumed when valid_o && ready_i.
  - v1 next = accepted ? 1 : (advance ? 0 : v1).
  - valid_o next = advance ? 1 : (consume ? 0 : valid_o).
- Latency: exactly 2 cycles from acceptance to valid_o when ready_i is held high. Throughput is 1 result per cycle.
- Stall: with valid_o && !ready_i, data_o, err_o and valid_o hold stable. Level 1 holds its contents if v1 = 1. Once both stages are full, ready_o = 0.
- Input sampling: data_i is sampled only in the acceptance cycle. Later changes to data_i do not affect in-flight results.
- Simultaneous consume and advance in one cycle: the new result replaces the old one; valid_o stays 1 with no bubble.
- Reset mid-operation: all in-flight requests are dropped with no output. Outputs return to reset values on the edge where rst_i = 1.
- Inputs while valid_i = 0 are ignored; no registers other than valid bits change.
- DEPTH = 2**address: err_o is always 0.

Test Plan:
1. Defaults; data_i[k] = k mod 16; sel = 0x2A7, valid_i = 1 for 1 cycle, ready_i = 1 -> valid_o rises exactly 2 cycles later with data_o = 0x7, err_o = 0; valid_o drops the following cycle.
2. Back-to-back sel = 0, 1, 2, … 1023 on consecutive cycles, ready_i = 1 -> 1024 consecutive results in order, each data_o = sel mod 16; ready_o never drops.
3. Issue sel = 5, 6, 7 with ready_i = 0 -> after 2 requests ready_o = 0 and data_o holds 5. Raise ready_i -> outputs 5, 6, 7 in order, none lost or duplicated.
4. DEPTH = 1000, data_i all 0xF; sel = 999 then 1000 -> results data_o = 0xF, err_o = 0, then data_o = 0, err_o = 1.
5. Accept sel = 3, change data_i[3] from 0x3 to 0xC the next cycle -> data_o = 0x3.
6. Accept two requests, then assert rst_i for 1 cycle while both are in flight -> valid_o = 0 and data_o = 0 from the next cycle; no stale result ever appears; ready_o = 1 after reset is released.
